// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state encoding shared by the run-of-two sequence detector.
package seq_det_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        S_A = 2'b00,
        S_B = 2'b01,
        S_C = 2'b10
    } state_t;
endpackage

// File: rtl/sequence_detector_2.sv
// sequence_detector_2: Moore FSM, z high while w was 1 on the last two edges.
module sequence_detector_2
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic w,
    output logic z
);
    state_t state;
    state_t state_nxt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_A;
        else state <= state_nxt;
    end
    // The unused code 2'b11 falls into default and recovers to A.
    always_comb begin
        state_nxt = S_A;
        case (state)
            S_A: state_nxt = w ? S_B : S_A;
            S_B: state_nxt = w ? S_C : S_A;
            S_C: state_nxt = w ? S_C : S_A;
            default: state_nxt = S_A;
        endcase
    end
    assign z = (state == S_C);
endmodule

// File: tb/tb_sequence_detector_2.sv
// tb_sequence_detector_2: directed vectors with hand-computed z for the detector.
module tb_sequence_detector_2;
    logic clk;
    logic reset;
    logic w;
    logic z;
    int vectors = 0;
    int miscompares = 0;

    sequence_detector_2 dut (
        .clk(clk),
        .reset(reset),
        .w(w),
        .z(z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic exp);
        vectors++;
        assert (z === exp) else begin
            miscompares++;
            $error("FAIL %s: z=%b expected %b", tag, z, exp);
        end
    endtask

    // w changes 1 time unit after a rising edge, z sampled 1 unit after the next one
    task automatic step(input string tag, input logic wv, input logic exp);
        w = wv;
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    // reset pulse placed between edges; z must drop without a clock edge
    task automatic pulse_reset(input string tag);
        #1 reset = 1'b1;
        #1 chk(tag, 1'b0);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        w = 1'b1;
        #1 reset = 1'b1;
        #1 chk("async_reset_t0", 1'b0);
        step("rst_hold0", 1'b1, 1'b0);
        step("rst_hold1", 1'b1, 1'b0);
        step("rst_hold2", 1'b1, 1'b0);
        reset = 1'b0;
        step("rel_first1", 1'b1, 1'b0);
        step("rel_second1", 1'b1, 1'b1);
        step("rel_clear", 1'b0, 1'b0);

        step("seq0", 1'b0, 1'b0);
        step("seq1", 1'b1, 1'b0);
        step("seq2", 1'b0, 1'b0);
        step("seq3", 1'b0, 1'b0);
        step("seq4", 1'b1, 1'b0);
        step("seq5", 1'b1, 1'b1);
        step("seq6", 1'b0, 1'b0);
        step("seq7", 1'b1, 1'b0);

        step("run_pre0", 1'b0, 1'b0);
        step("run1", 1'b1, 1'b0);
        step("run2", 1'b1, 1'b1);
        step("run3", 1'b1, 1'b1);
        step("run4", 1'b1, 1'b1);
        step("run5", 1'b1, 1'b1);
        step("run_end0", 1'b0, 1'b0);

        step("midC_1a", 1'b1, 1'b0);
        step("midC_1b", 1'b1, 1'b1);
        pulse_reset("midC_async_drop");
        step("midC_post0a", 1'b0, 1'b0);
        step("midC_post0b", 1'b0, 1'b0);
        step("midC_post1", 1'b1, 1'b0);

        step("midB_pre0", 1'b0, 1'b0);
        step("midB_1", 1'b1, 1'b0);
        pulse_reset("midB_reset");
        step("midB_post0", 1'b0, 1'b0);
        step("midB_post1a", 1'b1, 1'b0);
        step("midB_post1b", 1'b1, 1'b1);

        step("alt_pre0", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step($sformatf("alt%0d", i), (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
